alu_operand_seq: RTL and testbench

- Upstream sequencer for the 8-bit combinational ALU in the multicycle datapath.
- Accepts a command carrying the function code, then collects operand A and operand B from a shared one-word-per-cycle data bus.
- Drives the ALU inputs and captures the ALU result into a registered output with a valid/ready handshake.
- Gives the combinational ALU a clean registered front end and back end.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_operand_seq.sv | 135 +++++++++++++
 tb/tb_alu_operand_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU operand sequencer.
//   - ALU function codes (ADD, SUB, AND, NOT)
//   - sequencer FSM state encoding
//   - default datapath width
package alu_pkg;

    localparam int N_DEF = 8;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        EXEC  = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_operand_seq.sv
// alu_operand_seq: registered front/back end for a combinational N-bit ALU.
// Takes a command (function code), then collects operand A and operand B
// from a shared one-word-per-cycle data bus, presents them to the ALU, and
// captures the ALU result into a valid/ready-handshaked output register.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_func            function: 00 ADD, 01 SUB, 10 AND, 11 NOT
//   data_in/data_valid  operand bus
//   alu_inp1/2, alu_func  latched ALU inputs
//   alu_out             combinational ALU result
//   res_valid/ready     result handshake
//   res_data, res_zero  registered result and zero flag
//   res_carry           carry/borrow flag (only with ALU_CARRY_EN)
//   busy                high whenever not IDLE
//
// Optional feature macro: ALU_CARRY_EN adds the res_carry output and an
// internal (N+1)-bit adder/subtractor that derives it.
module alu_operand_seq
    import alu_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_func,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic [N-1:0] alu_inp1,
    output logic [N-1:0] alu_inp2,
    output logic [1:0]   alu_func,
    input  logic [N-1:0] alu_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_zero,
`ifdef ALU_CARRY_EN
    output logic         res_carry,
`endif
    output logic         busy
);

    state_t state;
    state_t state_next;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; GET_A/GET_B wait indefinitely for data_valid
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (cmd_valid) state_next = GET_A;
            GET_A: if (data_valid) state_next = (alu_func == ALU_NOT) ? EXEC : GET_B;
            GET_B: if (data_valid) state_next = EXEC;
            EXEC:  state_next = HOLD;
            HOLD:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        res_valid = (state == HOLD);
    end

`ifdef ALU_CARRY_EN
    // Bit N of the widened sum is carry-out for ADD and borrow for SUB
    logic [N:0] ext_sum;
    logic       carry_next;

    always_comb begin
        ext_sum = '0;
        case (alu_func)
            ALU_ADD: ext_sum = {1'b0, alu_inp1} + {1'b0, alu_inp2};
            ALU_SUB: ext_sum = {1'b0, alu_inp1} - {1'b0, alu_inp2};
            default: ext_sum = '0;
        endcase
    end

    assign carry_next = |(ext_sum >> N);
`endif

    // Operand, function and result registers. alu_* keep their values after
    // HOLD until the next command overwrites them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_inp1  <= '0;
            alu_inp2  <= '0;
            alu_func  <= ALU_ADD;
            res_data  <= '0;
            res_zero  <= 1'b0;
`ifdef ALU_CARRY_EN
            res_carry <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) alu_func <= cmd_func;
                end
                GET_A: begin
                    if (data_valid) begin
                        alu_inp1 <= data_in;
                        // NOT has no second operand; drive a clean zero
                        if (alu_func == ALU_NOT) alu_inp2 <= '0;
                    end
                end
                GET_B: begin
                    if (data_valid) alu_inp2 <= data_in;
                end
                EXEC: begin
                    res_data  <= alu_out;
                    res_zero  <= (alu_out == '0);
`ifdef ALU_CARRY_EN
                    res_carry <= carry_next;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_seq.sv
module tb_alu_operand_seq;
    import alu_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_func;
    logic [N-1:0] data_in;
    logic         data_valid;
    logic [N-1:0] alu_inp1;
    logic [N-1:0] alu_inp2;
    logic [1:0]   alu_func;
    logic [N-1:0] alu_out;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_zero;
`ifdef ALU_CARRY_EN
    logic         res_carry;
`endif
    logic         busy;

    int n_cmp;
    int n_fail;

    alu_operand_seq #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_func   (cmd_func),
        .data_in    (data_in),
        .data_valid (data_valid),
        .alu_inp1   (alu_inp1),
        .alu_inp2   (alu_inp2),
        .alu_func   (alu_func),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
`ifdef ALU_CARRY_EN
        .res_carry  (res_carry),
`endif
        .busy       (busy)
    );

    // Combinational ALU standing in for the real datapath ALU
    always_comb begin
        case (alu_func)
            ALU_ADD: alu_out = alu_inp1 + alu_inp2;
            ALU_SUB: alu_out = alu_inp1 - alu_inp2;
            ALU_AND: alu_out = alu_inp1 & alu_inp2;
            default: alu_out = ~alu_inp1;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue a command and feed operands with optional idle gaps. A decoy word
    // is driven with data_valid in the command cycle; it must not become A.
    // Returns the number of edges after the accept edge until res_valid.
    task automatic run_op(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b,
                          input int gap_a, input int gap_b, output int edges);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_func   = f;
        data_valid = 1'b1;
        data_in    = 8'h77;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        data_valid = 1'b0;
        edges = 0;
        chk("busy_after_accept", busy, 1);
        chk("cmd_ready_after_accept", cmd_ready, 0);
        repeat (gap_a) begin
            @(posedge clk); edges++; @(negedge clk);
            chk("busy_gap_a", busy, 1);
        end
        data_valid = 1'b1;
        data_in    = a;
        @(posedge clk); edges++; @(negedge clk);
        data_valid = 1'b0;
        if (f != ALU_NOT) begin
            repeat (gap_b) begin
                @(posedge clk); edges++; @(negedge clk);
                chk("busy_gap_b", busy, 1);
            end
            data_valid = 1'b1;
            data_in    = b;
            @(posedge clk); edges++; @(negedge clk);
            data_valid = 1'b0;
        end
        while (!res_valid && edges < 40) begin
            @(posedge clk); edges++; @(negedge clk);
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_after_ready", res_valid, 0);
        chk("cmd_ready_after_ready", cmd_ready, 1);
        chk("busy_after_ready", busy, 0);
    endtask

    typedef struct {
        logic [1:0] func;
        logic [7:0] a;
        logic [7:0] b;
        int         gap_a;
        int         gap_b;
        logic [7:0] res;
        logic       zero;
        logic       carry;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int edges;
        logic [7:0] exp_b;

        vecs[0] = '{ALU_ADD, 8'h05, 8'h03, 0, 0, 8'h08, 1'b0, 1'b0, 3};
        vecs[1] = '{ALU_SUB, 8'h03, 8'h03, 0, 0, 8'h00, 1'b1, 1'b0, 3};
        vecs[2] = '{ALU_SUB, 8'h02, 8'h05, 0, 0, 8'hFD, 1'b0, 1'b1, 3};
        vecs[3] = '{ALU_NOT, 8'hA5, 8'hEE, 0, 0, 8'h5A, 1'b0, 1'b0, 2};
        vecs[4] = '{ALU_ADD, 8'hFF, 8'h01, 0, 0, 8'h00, 1'b1, 1'b1, 3};
        vecs[5] = '{ALU_AND, 8'hF0, 8'h3C, 3, 2, 8'h30, 1'b0, 1'b0, 8};
        vecs[6] = '{ALU_ADD, 8'h7F, 8'h01, 1, 0, 8'h80, 1'b0, 1'b0, 4};

        n_cmp = 0;
        n_fail = 0;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_func   = 2'b00;
        data_in    = '0;
        data_valid = 1'b0;
        res_ready  = 1'b0;

        // Reset state
        #12;
        chk("rst_alu_inp1", alu_inp1, 0);
        chk("rst_alu_inp2", alu_inp2, 0);
        chk("rst_alu_func", alu_func, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_zero", res_zero, 0);
        chk("rst_busy", busy, 0);
`ifdef ALU_CARRY_EN
        chk("rst_res_carry", res_carry, 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_release", cmd_ready, 1);

        // res_ready while IDLE must not matter
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_ready_in_idle_busy", busy, 0);

        // Table of operations
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].gap_a, vecs[i].gap_b, edges);
            exp_b = (vecs[i].func == ALU_NOT) ? 8'h00 : vecs[i].b;
            chk($sformatf("v%0d_latency", i), edges, vecs[i].lat);
            chk($sformatf("v%0d_res_valid", i), res_valid, 1);
            chk($sformatf("v%0d_res_data", i), res_data, vecs[i].res);
            chk($sformatf("v%0d_res_zero", i), res_zero, vecs[i].zero);
            chk($sformatf("v%0d_alu_inp1", i), alu_inp1, vecs[i].a);
            chk($sformatf("v%0d_alu_inp2", i), alu_inp2, exp_b);
            chk($sformatf("v%0d_alu_func", i), alu_func, vecs[i].func);
`ifdef ALU_CARRY_EN
            chk($sformatf("v%0d_res_carry", i), res_carry, vecs[i].carry);
`endif
            release_result();
            chk($sformatf("v%0d_inp1_held", i), alu_inp1, vecs[i].a);
        end

        // Backpressure: result held for 5 cycles, commands ignored meanwhile
        run_op(ALU_ADD, 8'h10, 8'h20, 0, 0, edges);
        chk("bp_latency", edges, 3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmd_valid  = 1'b1;
            cmd_func   = ALU_NOT;
            data_valid = 1'b1;
            data_in    = 8'hEE;
            @(posedge clk);
            @(negedge clk);
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_data", res_data, 8'h30);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_alu_func", alu_func, ALU_ADD);
            chk("bp_alu_inp1", alu_inp1, 8'h10);
        end
        cmd_valid  = 1'b0;
        data_valid = 1'b0;
        release_result();

        // Reset asserted in GET_B aborts the operation
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_func  = ALU_SUB;
        @(posedge clk);
        @(negedge clk);
        cmd_valid  = 1'b0;
        data_valid = 1'b1;
        data_in    = 8'h40;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        chk("abort_inp1_latched", alu_inp1, 8'h40);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_alu_inp1", alu_inp1, 0);
        chk("abort_alu_inp2", alu_inp2, 0);
        chk("abort_alu_func", alu_func, 0);
        chk("abort_res_data", res_data, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", cmd_ready, 1);
        run_op(ALU_ADD, 8'h01, 8'h01, 0, 0, edges);
        chk("post_abort_latency", edges, 3);
        chk("post_abort_res_data", res_data, 8'h02);
        chk("post_abort_alu_inp2", alu_inp2, 8'h01);
        chk("post_abort_res_zero", res_zero, 0);
        release_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
